lfsr_rr_sched: RTL and testbench
================================

Name: lfsr_rr_sched

Overview:
- Arbitrated random-word server built around the team's 28-bit XNOR LFSR.
  - Same polynomial as the existing lfsr1.
  - Steps only when a word is consumed, so each random word goes to exactly one consumer.
- Up to NREQ requesters each ask for a burst of random words.
- A round-robin scheduler grants one requester at a time and streams words over a valid/ready handshake.
- Also sequences seeding of the LFSR.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 4, burst-length field width; encoded length L means L+1 words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester burst request; level, held until the burst ends.
- req_len  in  NREQ*LEN_W  per-requester length field; requester i uses bits [i*LEN_W +: LEN_W].
- seed_load  in  1  load seed into the LFSR (accepted in IDLE only).
- seed  in  28  seed value.
- gnt  out  NREQ  one-hot grant; all zero when idle.
- rnd_data  out  28  current LFSR state.
- rnd_valid  out  1  rnd_data is offered to the granted requester.
- rnd_ready  in  1  granted requester accepts the word.
- rnd_last  out  1  current word is the last of the burst.
- busy  out  1  state != IDLE.

Behaviour:
- LFSR q[27:0]:
  - next = {q[26:0], fb}, where fb = ~(q[27]^q[23]^q[16]^q[0]).
  - Steps only on a handshake (rnd_valid & rnd_ready).
  - All-ones is the lock-up state: a seed of 0xFFFFFFF loads 0x0000000 instead.
- Reset (async, resetn=0):
  - q=0, state=IDLE, rr pointer=0, remaining-count=0, granted index=0.
  - gnt=0, rnd_valid=0, rnd_last=0, busy=0; rnd_data=0.
- Two states, IDLE and BURST.
- IDLE:
  - seed_load=1: q <= seed (or 0 if all ones); no arbitration that cycle (seed wins over simultaneous req).
  - Else if any req: pick the first asserted req at or after the rr pointer, wrapping modulo NREQ.
    - Latch granted index g and cnt <= req_len[g].
    - Next state BURST.
  - gnt and rnd_valid are registered: req seen in cycle t -> gnt[g]=1 and rnd_valid=1 in cycle t+1.
- BURST:
  - gnt[g]=1.
  - rnd_valid = req[g] (combinational from the registered grant).
  - rnd_data=q; rnd_last = (cnt==0).
  - Handshake with cnt>0: q steps, cnt decrements.
  - Handshake with cnt==0: q steps; next cycle IDLE with gnt=0, rr pointer <= (g+1) mod NREQ.
  - req[g]=0 (abort): no transfer that cycle, q holds; next cycle IDLE, pointer <= (g+1) mod NREQ.
  - rnd_ready=0: rnd_data, cnt, q held stable; no timeout.
  - seed_load ignored.
- IDLE is always visited for one cycle between bursts, so back-to-back bursts have a one-cycle gap.
- Changes to req_len after the grant are ignored; the length is latched.
- Reset mid-burst: everything returns to reset values immediately; the partially served burst is not resumed.

Test Plan:
1. Reset, then req=0001, req_len[0]=2, rnd_ready=1 -> gnt=0001 one cycle later; words 0x0000000, 0x0000001, 0x0000002 with rnd_last on the third; gnt=0 next cycle; rnd_data=0x0000005 afterwards.
2. req=1111, all lengths 0, requesters drop req after their single word -> grants in order 0001, 0010, 0100, 1000, each separated by one idle cycle; re-raising req=1111 grants 0001 again.
3. Burst of 4 with rnd_ready low for 3 cycles after the second word -> rnd_data and rnd_valid held constant during the stall; exactly 4 distinct consecutive LFSR words delivered in total.
4. seed_load=1, seed=0x1234567 in IDLE together with req=0010 -> q=0x1234567, gnt rises one cycle later than normal, first word 0x1234567; seed 0xFFFFFFF -> first word 0x0000000.
5. req[2] granted for 8 words, drops after 3 handshakes -> gnt=0 next cycle; q advanced exactly 3 steps; next grant starts at requester 3.
6. resetn pulsed low mid-burst (between clocks) -> gnt, rnd_valid, busy and rnd_data go 0 without a clock edge; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/lfsr_rr_sched.sv
// Round-robin arbitrated server of 28-bit XNOR LFSR words. The LFSR advances only
// when a word is consumed, so every word reaches exactly one requester.
module lfsr_rr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  seed_load,
  input  logic [27:0]           seed,
  output logic [NREQ-1:0]       gnt,
  output logic [27:0]           rnd_data,
  output logic                  rnd_valid,
  input  logic                  rnd_ready,
  output logic                  rnd_last,
  output logic                  busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q;
  logic [27:0]       lfsr_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   idx_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [NREQ-1:0]   gnt_q;

  logic [27:0]       lfsr_next;
  logic [IdxW-1:0]   idx_inc;
  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;

  assign lfsr_next = {lfsr_q[26:0], ~(lfsr_q[27] ^ lfsr_q[23] ^ lfsr_q[16] ^ lfsr_q[0])};
  assign idx_inc   = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

  // First asserted request at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req[(int'(ptr_q) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign busy      = (state_q == StBurst);
  assign gnt       = gnt_q;
  assign rnd_data  = lfsr_q;
  assign rnd_valid = busy & req[idx_q];
  assign rnd_last  = busy & (cnt_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seed_load) begin
            // All-ones is the XNOR lock-up state; substitute zero.
            lfsr_q <= (&seed) ? '0 : seed;
          end else if (pick_found) begin
            idx_q   <= pick_idx;
            cnt_q   <= req_len[pick_idx*LEN_W +: LEN_W];
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (!req[idx_q]) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= idx_inc;
          end else if (rnd_ready) begin
            lfsr_q <= lfsr_next;
            if (cnt_q == '0) begin
              state_q <= StIdle;
              gnt_q   <= '0;
              ptr_q   <= idx_inc;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Directed bench for lfsr_rr_sched: arbitration order, LFSR sequence, stalls,
// seeding, aborts and asynchronous reset.
module tb_lfsr_rr_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic        seed_load;
  logic [27:0] seed;
  logic [3:0]  gnt;
  logic [27:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        rnd_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  lfsr_rr_sched #(.NREQ(4), .LEN_W(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_len   (req_len),
    .seed_load (seed_load),
    .seed      (seed),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_last  (rnd_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = '0; req_len = '0; seed_load = 1'b0; seed = '0; rnd_ready = 1'b1;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({gnt, rnd_valid, rnd_last, busy, rnd_data} !== {4'b0, 3'b0, 28'h0}) begin
      errors++;
      $display("FAIL reset: gnt=%b v=%b l=%b busy=%b data=%h, want all zero",
               gnt, rnd_valid, rnd_last, busy, rnd_data);
    end
  endtask

  task automatic test_basic_burst();
    logic [27:0] exp_w [3];
    exp_w = '{28'h0, 28'h1, 28'h2};
    do_reset();
    req = 4'b0001; req_len[3:0] = 4'd2; rnd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (gnt !== 4'b0001 || rnd_valid !== 1'b1 || rnd_data !== exp_w[i]
          || rnd_last !== (i == 2) || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic word%0d: gnt=%b v=%b data=%h last=%b, want 0001 1 %h %b",
                 i, gnt, rnd_valid, rnd_data, rnd_last, exp_w[i], i == 2);
      end
    end
    cyc();
    req = '0;
    #1;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || rnd_valid !== 1'b0 || rnd_data !== 28'h5) begin
      errors++;
      $display("FAIL basic end: gnt=%b busy=%b v=%b data=%h, want 0000 0 0 0000005",
               gnt, busy, rnd_valid, rnd_data);
    end
  endtask

  task automatic test_round_robin();
    logic [27:0] exp_w [4];
    exp_w = '{28'h0, 28'h1, 28'h2, 28'h5};
    do_reset();
    req = 4'b1111; req_len = '0; rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (gnt !== (4'b0001 << i) || rnd_data !== exp_w[i] || rnd_last !== 1'b1) begin
        errors++;
        $display("FAIL rr grant%0d: gnt=%b data=%h last=%b, want %b %h 1",
                 i, gnt, rnd_data, rnd_last, 4'b0001 << i, exp_w[i]);
      end
      cyc();
      req[i] = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr gap%0d: gnt=%b busy=%b, want 0000 0", i, gnt, busy);
      end
    end
    req = 4'b1111;
    cyc();
    checks++;
    if (gnt !== 4'b0001 || rnd_data !== 28'hA) begin
      errors++;
      $display("FAIL rr wrap: gnt=%b data=%h, want 0001 000000a", gnt, rnd_data);
    end
    req = '0;
    cyc();
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0001; req_len[3:0] = 4'd3; rnd_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    rnd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rnd_data !== 28'h2 || rnd_valid !== 1'b1 || rnd_last !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: data=%h v=%b last=%b, want 0000002 1 0",
                 i, rnd_data, rnd_valid, rnd_last);
      end
      cyc();
    end
    rnd_ready = 1'b1;
    cyc();
    checks++;
    if (rnd_data !== 28'h5 || rnd_last !== 1'b1 || rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall last: data=%h last=%b v=%b, want 0000005 1 1",
               rnd_data, rnd_last, rnd_valid);
    end
    cyc();
    req = '0;
    #1;
    checks++;
    if (gnt !== 4'b0 || rnd_data !== 28'hA) begin
      errors++;
      $display("FAIL stall end: gnt=%b data=%h, want 0000 000000a", gnt, rnd_data);
    end
  endtask

  task automatic test_seed();
    do_reset();
    seed_load = 1'b1; seed = 28'h1234567; req = 4'b0010; req_len = '0; rnd_ready = 1'b1;
    cyc();
    seed_load = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || rnd_data !== 28'h1234567) begin
      errors++;
      $display("FAIL seed load: gnt=%b data=%h, want 0000 1234567", gnt, rnd_data);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0010 || rnd_data !== 28'h1234567 || rnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL seed grant: gnt=%b data=%h v=%b, want 0010 1234567 1",
               gnt, rnd_data, rnd_valid);
    end
    cyc();
    req = '0;
    seed_load = 1'b1; seed = 28'hFFFFFFF;
    cyc();
    seed_load = 1'b0;
    #1;
    checks++;
    if (rnd_data !== 28'h0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL seed lockup: data=%h gnt=%b, want 0000000 0000", rnd_data, gnt);
    end
  endtask

  task automatic test_abort_and_async_reset();
    do_reset();
    req = 4'b0100; req_len[11:8] = 4'd7; rnd_ready = 1'b1;
    cyc();
    checks++;
    if (gnt !== 4'b0100 || rnd_data !== 28'h0) begin
      errors++;
      $display("FAIL abort grant: gnt=%b data=%h, want 0100 0000000", gnt, rnd_data);
    end
    cyc();
    cyc();
    cyc();
    req = '0;
    #1;
    checks++;
    if (rnd_valid !== 1'b0 || rnd_data !== 28'h5) begin
      errors++;
      $display("FAIL abort drop: v=%b data=%h, want 0 0000005", rnd_valid, rnd_data);
    end
    cyc();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || rnd_data !== 28'h5) begin
      errors++;
      $display("FAIL abort idle: gnt=%b busy=%b data=%h, want 0000 0 0000005",
               gnt, busy, rnd_data);
    end
    req = 4'b1111; req_len = '1;
    cyc();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL abort next: gnt=%b, want 1000", gnt);
    end
    cyc();
    resetn = 1'b0;
    #2;
    checks++;
    if ({gnt, rnd_valid, busy, rnd_data} !== {4'b0, 2'b0, 28'h0}) begin
      errors++;
      $display("FAIL async reset: gnt=%b v=%b busy=%b data=%h, want all zero",
               gnt, rnd_valid, busy, rnd_data);
    end
    resetn = 1'b1;
    cyc();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL post reset: gnt=%b, want 0001", gnt);
    end
    req = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_stall();
    test_seed();
    test_abort_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
